// File: rtl/alu_rs_scheduler_pkg.sv
// Shared widths, defaults and op encodings for the ALU reservation station.
// TAG_W_DEF must track the ROB entry range width.
package alu_rs_scheduler_pkg;
  localparam int RS_SIZE_DEF = 16;
  localparam int TAG_W_DEF   = 4;
  localparam int XLEN        = 32;
  localparam int OP_W        = 6;

  localparam logic [OP_W-1:0] OP_ADD = 6'd1;
  localparam logic [OP_W-1:0] OP_SUB = 6'd2;
  localparam logic [OP_W-1:0] OP_XOR = 6'd5;
  localparam logic [OP_W-1:0] OP_BEQ = 6'd20;
endpackage

// File: rtl/alu_rs_select.sv
// Picks one ready station entry: lowest index, or oldest when ALU_RS_AGE_SELECT_EN.
// Purely combinational; no backpressure.
module alu_rs_select
  import alu_rs_scheduler_pkg::*;
#(
  parameter int RS_SIZE = RS_SIZE_DEF,
  parameter int IDX_W   = $clog2(RS_SIZE)
) (
  input  logic [RS_SIZE-1:0]            ready,
`ifdef ALU_RS_AGE_SELECT_EN
  input  logic [RS_SIZE-1:0][IDX_W:0]   age,
  input  logic [IDX_W:0]                age_cnt,
`endif
  output logic [RS_SIZE-1:0]            grant,
  output logic [IDX_W-1:0]              grant_idx,
  output logic                          grant_vld
);
`ifdef ALU_RS_AGE_SELECT_EN
  logic [IDX_W:0] rel;
  logic [IDX_W:0] best_rel;

  // Distance back from the dispatch counter; the largest distance is the oldest entry.
  always_comb begin
    grant     = '0;
    grant_idx = '0;
    grant_vld = 1'b0;
    rel       = '0;
    best_rel  = '0;
    for (int i = 0; i < RS_SIZE; i++) begin
      rel = age_cnt - age[i];
      if (ready[i] && (!grant_vld || rel > best_rel)) begin
        grant_vld = 1'b1;
        grant_idx = IDX_W'(i);
        best_rel  = rel;
      end
    end
    if (grant_vld) grant[grant_idx] = 1'b1;
  end
`else
  always_comb begin
    grant     = '0;
    grant_idx = '0;
    grant_vld = 1'b0;
    for (int i = RS_SIZE - 1; i >= 0; i--) begin
      if (ready[i]) begin
        grant_vld = 1'b1;
        grant_idx = IDX_W'(i);
      end
    end
    if (grant_vld) grant[grant_idx] = 1'b1;
  end
`endif
endmodule

// File: rtl/alu_rs_scheduler.sv
// ALU reservation station: buffers dispatched ops, wakes operands from two CDBs, issues one per cycle.
// Issue registered one edge after an entry becomes ready; rs_full stalls dispatch; ALU_RS_AGE_SELECT_EN picks oldest.
module alu_rs_scheduler
  import alu_rs_scheduler_pkg::*;
#(
  parameter int RS_SIZE = RS_SIZE_DEF,
  parameter int IDX_W   = $clog2(RS_SIZE),
  parameter int TAG_W   = TAG_W_DEF
) (
  input  logic             clk_in,
  input  logic             rst_in,
  input  logic             rdy_in,
  input  logic             flush,
  input  logic             disp_valid,
  input  logic [OP_W-1:0]  disp_op,
  input  logic [XLEN-1:0]  disp_instruction,
  input  logic [XLEN-1:0]  disp_pc,
  input  logic [XLEN-1:0]  disp_imm,
  input  logic [TAG_W-1:0] disp_des,
  input  logic             disp_qj_valid,
  input  logic             disp_qk_valid,
  input  logic [TAG_W-1:0] disp_qj,
  input  logic [TAG_W-1:0] disp_qk,
  input  logic [XLEN-1:0]  disp_vj,
  input  logic [XLEN-1:0]  disp_vk,
  input  logic             cdb_alu_valid,
  input  logic [TAG_W-1:0] cdb_alu_tag,
  input  logic [XLEN-1:0]  cdb_alu_value,
  input  logic             cdb_lsb_valid,
  input  logic [TAG_W-1:0] cdb_lsb_tag,
  input  logic [XLEN-1:0]  cdb_lsb_value,
  output logic             rs_full,
  output logic             rs_new_calculate,
  output logic [OP_W-1:0]  rs_op,
  output logic [XLEN-1:0]  rs_instruction,
  output logic [XLEN-1:0]  rs_vj,
  output logic [XLEN-1:0]  rs_vk,
  output logic [XLEN-1:0]  rs_pc,
  output logic [XLEN-1:0]  rs_imm,
  output logic [TAG_W-1:0] rs_des
);
  localparam int CNT_W = IDX_W + 1;

  typedef struct packed {
    logic             pend;
    logic [TAG_W-1:0] tag;
    logic [XLEN-1:0]  val;
  } opnd_t;

  typedef struct packed {
    logic             vld;
    logic [TAG_W-1:0] tag;
    logic [XLEN-1:0]  val;
  } cdb_t;

  typedef struct packed {
    logic             busy;
    logic [OP_W-1:0]  op;
    logic [XLEN-1:0]  instr;
    logic [XLEN-1:0]  pc;
    logic [XLEN-1:0]  imm;
    logic [TAG_W-1:0] des;
    opnd_t            qj;
    opnd_t            qk;
`ifdef ALU_RS_AGE_SELECT_EN
    logic [CNT_W-1:0] age;
`endif
  } entry_t;

  typedef struct packed {
    logic             calc;
    logic [OP_W-1:0]  op;
    logic [XLEN-1:0]  instr;
    logic [XLEN-1:0]  vj;
    logic [XLEN-1:0]  vk;
    logic [XLEN-1:0]  pc;
    logic [XLEN-1:0]  imm;
    logic [TAG_W-1:0] des;
  } issue_t;

  // ALU port is checked first so it wins on the (illegal) equal-tag case.
  function automatic opnd_t snoop(opnd_t o, cdb_t a, cdb_t l);
    opnd_t r = o;
    if (o.pend && a.vld && a.tag == o.tag) begin
      r.pend = 1'b0;
      r.val  = a.val;
    end else if (o.pend && l.vld && l.tag == o.tag) begin
      r.pend = 1'b0;
      r.val  = l.val;
    end
    return r;
  endfunction

  entry_t             entries_q [RS_SIZE];
  entry_t             entries_d [RS_SIZE];
  logic [CNT_W-1:0]   count_q, count_d;
  issue_t             issue_q, issue_d;
  cdb_t               cdb_alu, cdb_lsb;
  logic [RS_SIZE-1:0] ready;
  logic [RS_SIZE-1:0] grant;
  logic [IDX_W-1:0]   grant_idx;
  logic               grant_vld;
  logic [IDX_W-1:0]   free_idx;
  logic               disp_acc;
`ifdef ALU_RS_AGE_SELECT_EN
  logic [CNT_W-1:0]   age_cnt_q, age_cnt_d;
  logic [RS_SIZE-1:0][CNT_W-1:0] ages;
`endif

  assign cdb_alu  = '{vld: cdb_alu_valid, tag: cdb_alu_tag, val: cdb_alu_value};
  assign cdb_lsb  = '{vld: cdb_lsb_valid, tag: cdb_lsb_tag, val: cdb_lsb_value};
  assign rs_full  = (count_q == CNT_W'(RS_SIZE));
  assign disp_acc = disp_valid && !rs_full;

  always_comb begin
    ready    = '0;
    free_idx = '0;
    for (int i = RS_SIZE - 1; i >= 0; i--) begin
      ready[i] = entries_q[i].busy && !entries_q[i].qj.pend && !entries_q[i].qk.pend;
      if (!entries_q[i].busy) free_idx = IDX_W'(i);
    end
  end

`ifdef ALU_RS_AGE_SELECT_EN
  always_comb begin
    ages = '0;
    for (int i = 0; i < RS_SIZE; i++) ages[i] = entries_q[i].age;
  end
`endif

  alu_rs_select #(.RS_SIZE(RS_SIZE), .IDX_W(IDX_W)) u_select (
    .ready     (ready),
`ifdef ALU_RS_AGE_SELECT_EN
    .age       (ages),
    .age_cnt   (age_cnt_q),
`endif
    .grant     (grant),
    .grant_idx (grant_idx),
    .grant_vld (grant_vld)
  );

  always_comb begin
    entries_d    = entries_q;
    count_d      = count_q;
    issue_d      = issue_q;
    issue_d.calc = 1'b0;
`ifdef ALU_RS_AGE_SELECT_EN
    age_cnt_d    = age_cnt_q;
`endif
    if (!rdy_in) begin
      entries_d = entries_q;
    end else if (flush) begin
      for (int i = 0; i < RS_SIZE; i++) entries_d[i].busy = 1'b0;
      count_d = '0;
`ifdef ALU_RS_AGE_SELECT_EN
      age_cnt_d = '0;
`endif
    end else begin
      for (int i = 0; i < RS_SIZE; i++) begin
        entries_d[i].qj = snoop(entries_q[i].qj, cdb_alu, cdb_lsb);
        entries_d[i].qk = snoop(entries_q[i].qk, cdb_alu, cdb_lsb);
        if (grant[i]) entries_d[i].busy = 1'b0;
      end
      if (grant_vld) begin
        issue_d = '{calc: 1'b1, op: entries_q[grant_idx].op, instr: entries_q[grant_idx].instr,
                    vj: entries_q[grant_idx].qj.val, vk: entries_q[grant_idx].qk.val,
                    pc: entries_q[grant_idx].pc, imm: entries_q[grant_idx].imm,
                    des: entries_q[grant_idx].des};
      end
      // The free slot comes from registered busy bits, so it never collides with the issuing entry.
      if (disp_acc) begin
        entries_d[free_idx].busy  = 1'b1;
        entries_d[free_idx].op    = disp_op;
        entries_d[free_idx].instr = disp_instruction;
        entries_d[free_idx].pc    = disp_pc;
        entries_d[free_idx].imm   = disp_imm;
        entries_d[free_idx].des   = disp_des;
        entries_d[free_idx].qj    = snoop('{pend: disp_qj_valid, tag: disp_qj, val: disp_vj}, cdb_alu, cdb_lsb);
        entries_d[free_idx].qk    = snoop('{pend: disp_qk_valid, tag: disp_qk, val: disp_vk}, cdb_alu, cdb_lsb);
`ifdef ALU_RS_AGE_SELECT_EN
        entries_d[free_idx].age   = age_cnt_q;
        age_cnt_d                 = age_cnt_q + 1'b1;
`endif
      end
      count_d = count_q + CNT_W'(disp_acc) - CNT_W'(grant_vld);
    end
  end

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      for (int i = 0; i < RS_SIZE; i++) entries_q[i] <= '0;
      count_q <= '0;
      issue_q <= '0;
`ifdef ALU_RS_AGE_SELECT_EN
      age_cnt_q <= '0;
`endif
    end else begin
      entries_q <= entries_d;
      count_q   <= count_d;
      issue_q   <= issue_d;
`ifdef ALU_RS_AGE_SELECT_EN
      age_cnt_q <= age_cnt_d;
`endif
    end
  end

  assign rs_new_calculate = issue_q.calc;
  assign rs_op            = issue_q.op;
  assign rs_instruction   = issue_q.instr;
  assign rs_vj            = issue_q.vj;
  assign rs_vk            = issue_q.vk;
  assign rs_pc            = issue_q.pc;
  assign rs_imm           = issue_q.imm;
  assign rs_des           = issue_q.des;
endmodule

// File: tb/tb_alu_rs_scheduler.sv
// Directed bench for alu_rs_scheduler: expected issues are queued at stimulus time and popped by a monitor.
module tb_alu_rs_scheduler;
  import alu_rs_scheduler_pkg::*;

  logic        clk_in = 1'b0;
  logic        rst_in = 1'b1;
  logic        rdy_in = 1'b1;
  logic        flush = 1'b0;
  logic        disp_valid = 1'b0;
  logic [5:0]  disp_op = '0;
  logic [31:0] disp_instruction = '0, disp_pc = '0, disp_imm = '0;
  logic [3:0]  disp_des = '0;
  logic        disp_qj_valid = 1'b0, disp_qk_valid = 1'b0;
  logic [3:0]  disp_qj = '0, disp_qk = '0;
  logic [31:0] disp_vj = '0, disp_vk = '0;
  logic        cdb_alu_valid = 1'b0, cdb_lsb_valid = 1'b0;
  logic [3:0]  cdb_alu_tag = '0, cdb_lsb_tag = '0;
  logic [31:0] cdb_alu_value = '0, cdb_lsb_value = '0;
  logic        rs_full, rs_new_calculate;
  logic [5:0]  rs_op;
  logic [31:0] rs_instruction, rs_vj, rs_vk, rs_pc, rs_imm;
  logic [3:0]  rs_des;

  int checks = 0;
  int errors = 0;

  typedef struct packed {
    logic [5:0]  op;
    logic [31:0] vj;
    logic [31:0] vk;
    logic [31:0] pc;
    logic [3:0]  des;
  } exp_t;
  exp_t exp_q[$];

  alu_rs_scheduler dut (
    .clk_in(clk_in), .rst_in(rst_in), .rdy_in(rdy_in), .flush(flush),
    .disp_valid(disp_valid), .disp_op(disp_op), .disp_instruction(disp_instruction),
    .disp_pc(disp_pc), .disp_imm(disp_imm), .disp_des(disp_des),
    .disp_qj_valid(disp_qj_valid), .disp_qk_valid(disp_qk_valid),
    .disp_qj(disp_qj), .disp_qk(disp_qk), .disp_vj(disp_vj), .disp_vk(disp_vk),
    .cdb_alu_valid(cdb_alu_valid), .cdb_alu_tag(cdb_alu_tag), .cdb_alu_value(cdb_alu_value),
    .cdb_lsb_valid(cdb_lsb_valid), .cdb_lsb_tag(cdb_lsb_tag), .cdb_lsb_value(cdb_lsb_value),
    .rs_full(rs_full), .rs_new_calculate(rs_new_calculate), .rs_op(rs_op),
    .rs_instruction(rs_instruction), .rs_vj(rs_vj), .rs_vk(rs_vk), .rs_pc(rs_pc),
    .rs_imm(rs_imm), .rs_des(rs_des)
  );

  always #5 clk_in = ~clk_in;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk_in);
    #1;
  endtask

  task automatic push_exp(input logic [5:0] op, input logic [31:0] vj, input logic [31:0] vk,
                          input logic [3:0] des);
    exp_q.push_back('{op: op, vj: vj, vk: vk, pc: 32'h0000_1000 + 32'(des), des: des});
  endtask

  task automatic dispatch(input logic [5:0] op, input logic [31:0] vj, input logic [31:0] vk,
                          input logic [3:0] des, input logic qjv, input logic [3:0] qj,
                          input logic qkv, input logic [3:0] qk);
    disp_valid = 1'b1;
    disp_op = op;  disp_vj = vj;  disp_vk = vk;  disp_des = des;
    disp_qj_valid = qjv;  disp_qj = qj;  disp_qk_valid = qkv;  disp_qk = qk;
    disp_pc = 32'h0000_1000 + 32'(des);
    disp_imm = 32'h0000_0040;
    disp_instruction = 32'h0000_0033;
    tick();
    disp_valid = 1'b0;
  endtask

  always @(negedge clk_in) begin
    if (!rst_in && rs_new_calculate) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_issue: got issue des=%0d vj=0x%08h, expected no issue", rs_des, rs_vj);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        check("issue_op", 32'(rs_op), 32'(e.op));
        check("issue_vj", rs_vj, e.vj);
        check("issue_vk", rs_vk, e.vk);
        check("issue_pc", rs_pc, e.pc);
        check("issue_des", 32'(rs_des), 32'(e.des));
      end
    end
  end

  initial begin
    tick();
    tick();
    check("reset_full", 32'(rs_full), 32'd0);
    check("reset_calc", 32'(rs_new_calculate), 32'd0);
    check("reset_vj", rs_vj, 32'd0);
    check("reset_des", 32'(rs_des), 32'd0);
    rst_in = 1'b0;
    tick();

    // Ready at dispatch: issue visible after the next edge, single-cycle pulse.
    push_exp(OP_ADD, 32'd5, 32'd7, 4'd3);
    dispatch(OP_ADD, 32'd5, 32'd7, 4'd3, 1'b0, 4'd0, 1'b0, 4'd0);
    check("add_lat0", 32'(rs_new_calculate), 32'd0);
    tick();
    check("add_lat1", 32'(rs_new_calculate), 32'd1);
    tick();
    check("add_pulse", 32'(rs_new_calculate), 32'd0);

    // qj pending, woken by LSB broadcast.
    dispatch(OP_SUB, 32'd0, 32'd1, 4'd4, 1'b1, 4'd2, 1'b0, 4'd0);
    for (int i = 0; i < 3; i++) begin
      tick();
      check("sub_wait", 32'(rs_new_calculate), 32'd0);
    end
    cdb_lsb_valid = 1'b1;  cdb_lsb_tag = 4'd2;  cdb_lsb_value = 32'h10;
    push_exp(OP_SUB, 32'h10, 32'd1, 4'd4);
    tick();
    cdb_lsb_valid = 1'b0;
    check("sub_lat0", 32'(rs_new_calculate), 32'd0);
    tick();
    check("sub_lat1", 32'(rs_new_calculate), 32'd1);
    tick();

    // Same-cycle bypass of an ALU broadcast into a dispatching entry.
    cdb_alu_valid = 1'b1;  cdb_alu_tag = 4'd6;  cdb_alu_value = 32'hFF;
    push_exp(OP_ADD, 32'd9, 32'hFF, 4'd5);
    dispatch(OP_ADD, 32'd9, 32'd0, 4'd5, 1'b0, 4'd0, 1'b1, 4'd6);
    cdb_alu_valid = 1'b0;
    check("byp_lat0", 32'(rs_new_calculate), 32'd0);
    tick();
    check("byp_lat1", 32'(rs_new_calculate), 32'd1);
    tick();

    // Fill all 16 entries, each waiting on its own tag.
    for (int i = 0; i < 16; i++) begin
      dispatch(OP_XOR, 32'd0, 32'(i), 4'(i), 1'b1, 4'(i), 1'b0, 4'd0);
      if (i == 14) check("fill_15_not_full", 32'(rs_full), 32'd0);
    end
    check("fill_16_full", 32'(rs_full), 32'd1);
    dispatch(OP_ADD, 32'hAA, 32'hBB, 4'd9, 1'b0, 4'd0, 1'b0, 4'd0);
    check("full_drop", 32'(rs_full), 32'd1);
    cdb_alu_valid = 1'b1;  cdb_alu_tag = 4'd7;  cdb_alu_value = 32'h77;
    push_exp(OP_XOR, 32'h77, 32'd7, 4'd7);
    tick();
    cdb_alu_valid = 1'b0;
    check("full_wake_still_full", 32'(rs_full), 32'd1);
    tick();
    check("full_wake_issue", 32'(rs_new_calculate), 32'd1);
    check("full_wake_drop", 32'(rs_full), 32'd0);
    flush = 1'b1;
    tick();
    flush = 1'b0;

    // Flush with four pending entries and a same-cycle dispatch.
    for (int i = 1; i <= 4; i++) dispatch(OP_ADD, 32'd0, 32'd0, 4'(i), 1'b1, 4'(i), 1'b0, 4'd0);
    flush = 1'b1;
    dispatch(OP_ADD, 32'hDEAD, 32'h1, 4'd8, 1'b0, 4'd0, 1'b0, 4'd0);
    flush = 1'b0;
    check("flush_full", 32'(rs_full), 32'd0);
    check("flush_calc", 32'(rs_new_calculate), 32'd0);
    for (int i = 1; i <= 4; i++) begin
      cdb_alu_valid = 1'b1;  cdb_alu_tag = 4'(i);  cdb_alu_value = 32'h5;
      tick();
    end
    cdb_alu_valid = 1'b0;
    tick();
    tick();
    for (int i = 0; i < 16; i++) begin
      dispatch(OP_ADD, 32'd0, 32'd0, 4'(i), 1'b1, 4'd9, 1'b0, 4'd0);
      if (i == 14) check("refill_15_not_full", 32'(rs_full), 32'd0);
    end
    check("refill_16_full", 32'(rs_full), 32'd1);
    flush = 1'b1;
    tick();
    flush = 1'b0;
    check("reflush_full", 32'(rs_full), 32'd0);

    // Pause with two ready entries; the older one sits at the higher index.
    dispatch(OP_ADD, 32'd0, 32'h11, 4'd10, 1'b1, 4'd1, 1'b0, 4'd0);
    dispatch(OP_SUB, 32'd0, 32'h22, 4'd11, 1'b1, 4'd2, 1'b0, 4'd0);
    dispatch(OP_ADD, 32'd0, 32'h33, 4'd12, 1'b1, 4'd3, 1'b0, 4'd0);
    cdb_lsb_valid = 1'b1;  cdb_lsb_tag = 4'd1;  cdb_lsb_value = 32'hA1;
    push_exp(OP_ADD, 32'hA1, 32'h11, 4'd10);
    tick();
    cdb_lsb_valid = 1'b0;
    tick();
    dispatch(OP_BEQ, 32'd0, 32'h44, 4'd13, 1'b1, 4'd2, 1'b0, 4'd0);
    cdb_alu_valid = 1'b1;  cdb_alu_tag = 4'd2;  cdb_alu_value = 32'hB2;
`ifdef ALU_RS_AGE_SELECT_EN
    push_exp(OP_SUB, 32'hB2, 32'h22, 4'd11);
    push_exp(OP_BEQ, 32'hB2, 32'h44, 4'd13);
`else
    push_exp(OP_BEQ, 32'hB2, 32'h44, 4'd13);
    push_exp(OP_SUB, 32'hB2, 32'h22, 4'd11);
`endif
    tick();
    rdy_in = 1'b0;
    cdb_alu_tag = 4'd3;
    disp_valid = 1'b1;  disp_op = OP_ADD;  disp_vj = 32'hEE;  disp_des = 4'd14;
    disp_qj_valid = 1'b0;  disp_qk_valid = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      check("pause_no_issue", 32'(rs_new_calculate), 32'd0);
    end
    cdb_alu_valid = 1'b0;
    disp_valid = 1'b0;
    rdy_in = 1'b1;
    tick();
    check("resume_issue1", 32'(rs_new_calculate), 32'd1);
    tick();
    check("resume_issue2", 32'(rs_new_calculate), 32'd1);
    tick();
    check("resume_idle", 32'(rs_new_calculate), 32'd0);

    flush = 1'b1;
    tick();
    flush = 1'b0;
    tick();
    tick();
    check("sb_drained", 32'(exp_q.size()), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
